// File: rtl/serial_mag_comparator_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mag_comparator_pkg
//  Purpose  : Shared definitions for the serial magnitude comparator:
//             FSM state encoding, slice width and counter sizing helper.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package serial_mag_comparator_pkg;

    // Bits examined per clock.
    localparam int SLICE_W = 2;

    // FSM state encoding.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_CMP  = 1'b1;

    // Slice counter width: $clog2(nslice), but never less than one bit.
    function automatic int cnt_width(input int nslice);
        return (nslice > 1) ? $clog2(nslice) : 1;
    endfunction

endpackage : serial_mag_comparator_pkg
`default_nettype wire

// File: rtl/comparator_2bit.sv
`default_nettype none
// ============================================================================
//  Module   : comparator_2bit
//  Purpose  : Combinational unsigned magnitude compare of two 2-bit values.
//  Ports    : a, b   in  [1:0]  operands
//             lt     out        a <  b
//             eq     out        a == b
//             gt     out        a >  b
//  Revision : 1.0  initial release
// ============================================================================
module comparator_2bit (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic       lt,
    output logic       eq,
    output logic       gt
);

    assign lt = (a <  b);
    assign eq = (a == b);
    assign gt = (a >  b);

endmodule : comparator_2bit
`default_nettype wire

// File: rtl/serial_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : serial_mag_comparator
//  Purpose  : Sequential unsigned magnitude comparator. Walks two WIDTH-bit
//             operands MSB-first, one 2-bit slice per clock, and stops at the
//             first differing slice. Result is registered with a done pulse.
//  Ports    : clk    in             rising-edge clock
//             rst    in             synchronous reset, active-high
//             start  in             request, sampled only while idle
//             a, b   in  [WIDTH-1:0] operands, captured on accepted start
//             busy   out            comparison in progress
//             done   out            one-cycle pulse, result valid
//             lt/eq/gt out          result flags, held until next done
//  Revision : 1.0  initial release
// ============================================================================
module serial_mag_comparator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    import serial_mag_comparator_pkg::*;

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CNT_W  = cnt_width(NSLICE);

    state_t             r_state;
    logic [WIDTH-1:0]   r_sa;
    logic [WIDTH-1:0]   r_sb;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_lt;
    logic               w_eq;
    logic               w_gt;

    // The top slice of the shift registers is always the one under test.
    comparator_2bit u_cmp (
        .a  (r_sa[WIDTH-1 -: SLICE_W]),
        .b  (r_sb[WIDTH-1 -: SLICE_W]),
        .lt (w_lt),
        .eq (w_eq),
        .gt (w_gt)
    );

    assign busy = (r_state == ST_CMP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sa    <= '0;
            r_sb    <= '0;
            r_cnt   <= '0;
            done    <= 1'b0;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= b;
                        r_cnt   <= CNT_W'(NSLICE - 1);
                        r_state <= ST_CMP;
                    end
                end
                ST_CMP: begin
                    if (!w_eq) begin
                        // First differing slice decides the whole compare.
                        lt      <= w_lt;
                        eq      <= 1'b0;
                        gt      <= w_gt;
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end else if (r_cnt == '0) begin
                        // Last slice and still equal: operands are identical.
                        lt      <= 1'b0;
                        eq      <= 1'b1;
                        gt      <= 1'b0;
                        done    <= 1'b1;
                        r_state <= ST_IDLE;
                    end else begin
                        r_sa    <= r_sa << SLICE_W;
                        r_sb    <= r_sb << SLICE_W;
                        r_cnt   <= r_cnt - 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule : serial_mag_comparator
`default_nettype wire

// File: tb/tb_serial_mag_comparator.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_mag_comparator
//  Purpose  : Self-checking bench for serial_mag_comparator (WIDTH=8).
//             A cycle-level behavioural model, driven from the operand
//             values and the latency rule, is checked against the DUT every
//             cycle; directed tests add hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_serial_mag_comparator;

    localparam int W  = 8;
    localparam int NS = W / 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy, done, lt, eq, gt;

    int assertions = 0;
    int failures   = 0;

    serial_mag_comparator #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .lt    (lt),
        .eq    (eq),
        .gt    (gt)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    // Index (1..NS) of the first differing 2-bit slice from the MSB end.
    function automatic int m_latency(input logic [W-1:0] x, input logic [W-1:0] y);
        for (int i = 1; i <= NS; i++) begin
            if (((x >> (W - 2*i)) & 3) != ((y >> (W - 2*i)) & 3)) return i;
        end
        return NS;
    endfunction

    // {lt, eq, gt} from plain arithmetic comparison.
    function automatic logic [2:0] m_result(input logic [W-1:0] x, input logic [W-1:0] y);
        if (x < y)       return 3'b100;
        else if (x == y) return 3'b010;
        else             return 3'b001;
    endfunction

    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_res  = 3'b000;
    logic [2:0] m_pend = 3'b000;
    int         m_rem  = 0;
    logic       chk_en = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = 3'b000;
            m_rem  = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_rem  = m_latency(a, b);
                m_pend = m_result(a, b);
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            assertions++;
            if ({busy, done, lt, eq, gt} !== {m_busy, m_done, m_res}) begin
                failures++;
                $display("FAIL model_cycle t=%0t: dut busy,done,lt,eq,gt=%b expected %b",
                         $time, {busy, done, lt, eq, gt}, {m_busy, m_done, m_res});
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input int act, input int exp);
        assertions++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge while idle. Pulses start for one cycle, then
    // counts cycles until done (bounded). Returns latency and busy count.
    task automatic run_cmp(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                           output int lat, output int nbusy);
        a = ta; b = tb_v; start = 1'b1;
        @(negedge clk);            // start accepted at the edge just passed
        start = 1'b0;
        lat = 0;
        nbusy = busy ? 1 : 0;
        do begin
            @(negedge clk);
            lat++;
            if (busy) nbusy++;
        end while (!done && lat < 20);
    endtask

    // Directed vector table: a, b, expected latency, expected {lt,eq,gt}.
    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        int           lat;
        logic [2:0]   res;
    } vec_t;

    vec_t vecs[6];

    int lat, nbusy, n;

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 4, 3'b010};
        vecs[1] = '{8'h80, 8'h7F, 1, 3'b001};
        vecs[2] = '{8'h1F, 8'h2F, 2, 3'b100};
        vecs[3] = '{8'hFF, 8'hFE, 4, 3'b001};
        vecs[4] = '{8'h04, 8'h08, 3, 3'b100};
        vecs[5] = '{8'h00, 8'h00, 4, 3'b010};

        // Pin the model against hand-computed values.
        check("model_lat_A5_A5", m_latency(8'hA5, 8'hA5), 4);
        check("model_lat_80_7F", m_latency(8'h80, 8'h7F), 1);
        check("model_lat_1F_2F", m_latency(8'h1F, 8'h2F), 2);
        check("model_lat_34_36", m_latency(8'h34, 8'h36), 4);
        check("model_res_34_36", int'(m_result(8'h34, 8'h36)), 4);

        rst = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", int'({busy, done, lt, eq, gt}), 0);
        chk_en = 1'b1;
        rst = 1'b0;
        @(negedge clk);

        // Directed table (covers tests 1-3 plus extra patterns).
        for (int i = 0; i < 6; i++) begin
            run_cmp(vecs[i].va, vecs[i].vb, lat, nbusy);
            check($sformatf("lat_%02h_%02h", vecs[i].va, vecs[i].vb), lat, vecs[i].lat);
            check($sformatf("res_%02h_%02h", vecs[i].va, vecs[i].vb),
                  int'({lt, eq, gt}), int'(vecs[i].res));
            if (i == 0) check("busy_cycles_A5", nbusy, 4);
            @(negedge clk);
        end

        // Test 4: start while busy is ignored; operand changes have no effect.
        a = 8'h34; b = 8'h36; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 8'hFF; b = 8'h00; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 2;
        while (!done && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("busy_start_lat", n, 4);
        check("busy_start_res", int'({lt, eq, gt}), 4);
        @(negedge clk);
        check("busy_start_not_recaptured", int'(busy), 0);

        // Test 5: start held across the done cycle -> back-to-back compare.
        a = 8'hC0; b = 8'h40; start = 1'b1;
        @(negedge clk);                       // first compare accepted
        a = 8'h00; b = 8'h00;
        @(negedge clk);                       // done edge; start ignored here
        check("b2b_first_done", int'(done), 1);
        check("b2b_first_res", int'({lt, eq, gt}), 1);
        @(negedge clk);                       // second compare accepted
        start = 1'b0;
        check("b2b_second_busy", int'(busy), 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done && n < 20);
        check("b2b_second_lat", n, 4);
        check("b2b_second_res", int'({lt, eq, gt}), 2);
        @(negedge clk);

        // Test 6: reset during the second CMP cycle aborts the compare.
        a = 8'h12; b = 8'h13; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_outputs", int'({busy, done, lt, eq, gt}), 0);
        n = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) n++;
        end
        check("abort_no_done", n, 0);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule : tb_serial_mag_comparator
`default_nettype wire
